bus2reg_arbiter: RTL and testbench

BUS2REG_ARBITER -- requirements
Module: bus2reg_arbiter

---
 rtl/bus2reg_arbiter.sv | 152 +++++++++++++++
 tb/tb_bus2reg_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus2reg_arbiter.sv
// Round-robin arbiter sharing one Bus2Reg master between two requesters, with a busy-cycle timeout.
// Latency: 1 cycle mN_req->bus_req, 1 cycle bus_ready->mN_ready; back-to-back grants at best every 3 cycles.
// Backpressure: requesters hold mN_req until mN_ready; bus_ready stalls the access for up to TIMEOUT_CYCLES cycles.
module bus2reg_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,

    input  logic                  m0_req,
    input  logic                  m0_req_is_wr,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wr_data,
    input  logic [DATA_WIDTH-1:0] m0_wr_biten,
    output logic                  m0_ready,
    output logic [DATA_WIDTH-1:0] m0_rd_data,
    output logic                  m0_err,

    input  logic                  m1_req,
    input  logic                  m1_req_is_wr,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wr_data,
    input  logic [DATA_WIDTH-1:0] m1_wr_biten,
    output logic                  m1_ready,
    output logic [DATA_WIDTH-1:0] m1_rd_data,
    output logic                  m1_err,

    output logic                  bus_req,
    output logic                  bus_req_is_wr,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wr_data,
    output logic [DATA_WIDTH-1:0] bus_wr_biten,
    output logic                  bus_req_stall_wr,
    output logic                  bus_req_stall_rd,
    input  logic                  bus_ready,
    input  logic [DATA_WIDTH-1:0] bus_rd_data
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int CNT_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
    localparam logic TO_EN   = (TIMEOUT_CYCLES > 0);

    typedef struct packed {
        logic                  is_wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wr_data;
        logic [DATA_WIDTH-1:0] wr_biten;
    } req_t;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic                  last_grant;
    logic                  grant;
    logic                  win;
    logic                  any_req;
    logic [CNT_W-1:0]      busy_cnt;
    req_t                  m0_fields;
    req_t                  m1_fields;
    req_t                  win_fields;
    req_t                  hold;
    logic                  done_ok;
    logic                  done_to;
    logic [DATA_WIDTH-1:0] done_data;

    assign m0_fields = {m0_req_is_wr, m0_addr, m0_wr_data, m0_wr_biten};
    assign m1_fields = {m1_req_is_wr, m1_addr, m1_wr_data, m1_wr_biten};
    assign any_req   = m0_req | m1_req;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        win = 1'b0;
        if (m0_req && m1_req) begin
            win = ~last_grant;
        end else if (m1_req) begin
            win = 1'b1;
        end
    end

    assign win_fields = win ? m1_fields : m0_fields;

    // A bus_ready on the last allowed cycle still counts as a normal completion.
    assign done_ok   = (state == ST_BUSY) && bus_ready;
    assign done_to   = (state == ST_BUSY) && !bus_ready && TO_EN && (busy_cnt == TO_LAST);
    assign done_data = done_ok ? bus_rd_data : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (any_req) state_nxt = ST_BUSY;
            ST_BUSY: if (done_ok || done_to) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            busy_cnt   <= '0;
            hold       <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && any_req) begin
                grant      <= win;
                last_grant <= win;
                busy_cnt   <= '0;
                hold       <= win_fields;
            end else if (state == ST_BUSY) begin
                busy_cnt <= busy_cnt + CNT_W'(1);
            end
        end
    end

    // Read data and error persist per requester until its next completion.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            m0_rd_data <= '0;
            m0_err     <= 1'b0;
            m1_rd_data <= '0;
            m1_err     <= 1'b0;
        end else if (done_ok || done_to) begin
            if (grant) begin
                m1_rd_data <= done_data;
                m1_err     <= done_to;
            end else begin
                m0_rd_data <= done_data;
                m0_err     <= done_to;
            end
        end
    end

    assign m0_ready = (state == ST_RESP) && !grant;
    assign m1_ready = (state == ST_RESP) && grant;

    assign bus_req          = (state == ST_BUSY);
    assign bus_req_is_wr    = hold.is_wr;
    assign bus_addr         = hold.addr;
    assign bus_wr_data      = hold.wr_data;
    assign bus_wr_biten     = hold.wr_biten;
    assign bus_req_stall_wr = 1'b0;
    assign bus_req_stall_rd = 1'b0;

endmodule

// File: tb/tb_bus2reg_arbiter.sv
// Randomized + directed bench for bus2reg_arbiter against a timestamp-based transaction model.
module tb_bus2reg_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic          m0_req = 1'b0, m0_req_is_wr = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wr_data = '0, m0_wr_biten = '0;
    logic          m1_req = 1'b0, m1_req_is_wr = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wr_data = '0, m1_wr_biten = '0;
    logic          bus_ready = 1'b0;
    logic [DW-1:0] bus_rd_data = '0;
    logic          m0_ready, m0_err, m1_ready, m1_err;
    logic [DW-1:0] m0_rd_data, m1_rd_data;
    logic          bus_req, bus_req_is_wr, bus_req_stall_wr, bus_req_stall_rd;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wr_data, bus_wr_biten;

    bus2reg_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .m0_req(m0_req), .m0_req_is_wr(m0_req_is_wr), .m0_addr(m0_addr),
        .m0_wr_data(m0_wr_data), .m0_wr_biten(m0_wr_biten),
        .m0_ready(m0_ready), .m0_rd_data(m0_rd_data), .m0_err(m0_err),
        .m1_req(m1_req), .m1_req_is_wr(m1_req_is_wr), .m1_addr(m1_addr),
        .m1_wr_data(m1_wr_data), .m1_wr_biten(m1_wr_biten),
        .m1_ready(m1_ready), .m1_rd_data(m1_rd_data), .m1_err(m1_err),
        .bus_req(bus_req), .bus_req_is_wr(bus_req_is_wr), .bus_addr(bus_addr),
        .bus_wr_data(bus_wr_data), .bus_wr_biten(bus_wr_biten),
        .bus_req_stall_wr(bus_req_stall_wr), .bus_req_stall_rd(bus_req_stall_rd),
        .bus_ready(bus_ready), .bus_rd_data(bus_rd_data)
    );

    always #5 ACLK = ~ACLK;

    int n_chk = 0, n_pass = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Per-transaction bus responder script, indexed by grant order.
    int            delays [1024];
    logic [DW-1:0] rdv    [1024];
    int            ridx = 0, bcnt = 0;
    bit            was_busy = 0;
    logic          seen0 = 0, seen1 = 0;
    int            auto_pct [2] = '{0, 0};

    // DUT observations made by the compare process.
    int            ob_len = 0, last_len = 0;
    bit            ob_in = 0, ob_stable = 0, last_stable = 0;
    logic [AW-1:0] ob_addr, last_addr;
    logic [DW-1:0] ob_wd, ob_be, last_wd, last_be;
    logic          ob_wr, last_wr;
    int            ready_log [$];

    // Transaction-level model: each grant books a window of cycles by timestamp.
    int            cyc = 0, midx = 0, m_d = 0, m_len = 0;
    int            m_bs = -10, m_be = -10, m_resp = -10, m_next = 0;
    logic          m_w = 1'b0, m_last = 1'b1, m_errp = 1'b0;
    logic          e_wr = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wd = '0, e_be = '0;
    logic [DW-1:0] e_rd [2] = '{'0, '0};
    logic          e_err [2] = '{1'b0, 1'b0};

    initial begin : compare_proc
        forever begin
            @(negedge ACLK);
            cyc++;
            if (!ARESETN) begin
                m_bs = -10; m_be = -10; m_resp = -10; m_next = 0; m_last = 1'b1;
                e_wr = 1'b0; e_addr = '0; e_wd = '0; e_be = '0;
                e_rd[0] = '0; e_rd[1] = '0; e_err[0] = 1'b0; e_err[1] = 1'b0;
            end
            chk("bus_req", bus_req, (cyc >= m_bs && cyc <= m_be));
            chk("bus_req_is_wr", bus_req_is_wr, e_wr);
            chk("bus_addr", bus_addr, e_addr);
            chk("bus_wr_data", bus_wr_data, e_wd);
            chk("bus_wr_biten", bus_wr_biten, e_be);
            chk("m0_ready", m0_ready, (cyc == m_resp && m_w == 1'b0));
            chk("m1_ready", m1_ready, (cyc == m_resp && m_w == 1'b1));
            chk("m0_rd_data", m0_rd_data, e_rd[0]);
            chk("m1_rd_data", m1_rd_data, e_rd[1]);
            chk("m0_err", m0_err, e_err[0]);
            chk("m1_err", m1_err, e_err[1]);
            chk("stall_wr", bus_req_stall_wr, 1'b0);
            chk("stall_rd", bus_req_stall_rd, 1'b0);

            if (bus_req) begin
                if (!ob_in) begin
                    ob_in = 1; ob_len = 0; ob_stable = 1;
                    ob_addr = bus_addr; ob_wd = bus_wr_data; ob_be = bus_wr_biten; ob_wr = bus_req_is_wr;
                end else if (bus_addr !== ob_addr || bus_wr_data !== ob_wd ||
                             bus_wr_biten !== ob_be || bus_req_is_wr !== ob_wr) begin
                    ob_stable = 0;
                end
                ob_len++;
            end else if (ob_in) begin
                ob_in = 0; last_len = ob_len; last_stable = ob_stable;
                last_addr = ob_addr; last_wd = ob_wd; last_be = ob_be; last_wr = ob_wr;
            end
            if (m0_ready) ready_log.push_back(0);
            if (m1_ready) ready_log.push_back(1);

            if (ARESETN) begin
                if (cyc == m_be) begin
                    e_err[m_w] = m_errp;
                    e_rd[m_w]  = m_errp ? '0 : bus_rd_data;
                end
                if (cyc >= m_next && (m0_req || m1_req)) begin
                    if (m0_req && m1_req) m_w = ~m_last;
                    else                  m_w = m1_req;
                    m_last = m_w;
                    m_d    = delays[midx % 1024];
                    midx++;
                    m_errp = (TO > 0) && (m_d > TO);
                    m_len  = m_errp ? TO : m_d;
                    m_bs   = cyc + 1;
                    m_be   = cyc + m_len;
                    m_resp = cyc + m_len + 1;
                    m_next = cyc + m_len + 2;
                    if (m_w) begin
                        e_wr = m1_req_is_wr; e_addr = m1_addr; e_wd = m1_wr_data; e_be = m1_wr_biten;
                    end else begin
                        e_wr = m0_req_is_wr; e_addr = m0_addr; e_wd = m0_wr_data; e_be = m0_wr_biten;
                    end
                end
            end
        end
    end

    task automatic set_req(input int n, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] be);
        if (n == 0) begin
            m0_req = 1'b1; m0_req_is_wr = wr; m0_addr = a; m0_wr_data = wd; m0_wr_biten = be;
        end else begin
            m1_req = 1'b1; m1_req_is_wr = wr; m1_addr = a; m1_wr_data = wd; m1_wr_biten = be;
        end
    endtask

    task automatic rand_req(input int n);
        set_req(n, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);
    endtask

    // One clock: note completions at the negedge, then drive responder and requesters after the edge.
    task automatic step();
        @(negedge ACLK);
        seen0 = m0_ready;
        seen1 = m1_ready;
        @(posedge ACLK);
        #1;
        if (bus_req) begin
            bcnt++;
            was_busy = 1;
            if (bcnt == delays[ridx % 1024]) begin
                bus_ready = 1'b1; bus_rd_data = rdv[ridx % 1024];
            end else begin
                bus_ready = 1'b0; bus_rd_data = $urandom;
            end
        end else begin
            bus_ready = 1'b0; bus_rd_data = $urandom;
            if (was_busy) ridx++;
            was_busy = 0; bcnt = 0;
        end
        if (seen0) m0_req = 1'b0;
        if (seen1) m1_req = 1'b0;
        if (!m0_req && $urandom_range(0, 99) < auto_pct[0]) rand_req(0);
        if (!m1_req && $urandom_range(0, 99) < auto_pct[1]) rand_req(1);
    endtask

    task automatic wait_ready(input int n, input int maxc, output int steps);
        bit got = 0;
        steps = 0;
        while (!got && steps < maxc) begin
            step();
            steps++;
            got = (n == 0) ? seen0 : seen1;
        end
        if (n == 0) chk("wait_m0_ready", got, 1'b1);
        else        chk("wait_m1_ready", got, 1'b1);
    endtask

    task automatic drain();
        int i = 0;
        while ((m0_req || m1_req || bus_req) && i < 300) begin
            step();
            i++;
        end
        chk("drain_idle", {m0_req, m1_req, bus_req}, 3'b000);
        step();
        step();
    endtask

    task automatic pulse_reset();
        #2;
        ARESETN = 1'b0;
        m0_req = 1'b0;
        m1_req = 1'b0;
        #1;
        chk("async_reset_bus_req", bus_req, 1'b0);
        repeat (3) step();
        ARESETN = 1'b1;
        step();
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got time limit %0t, expected completion earlier", $time);
        $fatal(1, "bench time limit");
    end

    initial begin : stim
        int k, n0, j;
        for (int i = 0; i < 1024; i++) begin
            delays[i] = $urandom_range(1, 6);
            rdv[i]    = $urandom;
        end

        repeat (2) step();
        chk("rst_bus_req", bus_req, 1'b0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_m0_ready", m0_ready, 1'b0);
        chk("rst_m1_rd_data", m1_rd_data, 32'h0);
        ARESETN = 1'b1;
        step();

        // single read, prompt bus_ready
        delays[ridx % 1024] = 1;
        rdv[ridx % 1024]    = 32'hCAFE0001;
        set_req(0, 1'b0, 32'h10, 32'h0, 32'h0);
        step();
        chk("t2_bus_req_rise", bus_req, 1'b1);
        chk("t2_bus_addr", bus_addr, 32'h10);
        wait_ready(0, 10, k);
        chk("t2_ready_latency", k, 2);
        chk("t2_busy_len", last_len, 1);
        chk("t2_is_wr", last_wr, 1'b0);
        chk("t2_rd_data", m0_rd_data, 32'hCAFE0001);
        chk("t2_err", m0_err, 1'b0);

        // tie straight after reset: m0 first, then m1's write
        pulse_reset();
        delays[ridx % 1024]       = 1;
        delays[(ridx + 1) % 1024] = 1;
        ready_log.delete();
        set_req(0, 1'b0, 32'h30, 32'h0, 32'h0);
        set_req(1, 1'b1, 32'h20, 32'h5A5A5A5A, 32'h0000FFFF);
        wait_ready(0, 10, k);
        chk("t3_first_is_m0", ready_log.size() == 1 && ready_log[0] == 0, 1'b1);
        wait_ready(1, 10, k);
        chk("t3_m1_resp_gap", k, 3);
        chk("t3_bus_addr", last_addr, 32'h20);
        chk("t3_bus_wr_data", last_wd, 32'h5A5A5A5A);
        chk("t3_bus_wr_biten", last_be, 32'h0000FFFF);
        chk("t3_is_wr", last_wr, 1'b1);

        // fairness under continuous demand
        ready_log.delete();
        auto_pct[0] = 100;
        auto_pct[1] = 100;
        rand_req(0);
        rand_req(1);
        j = 0;
        while (ready_log.size() < 6 && j < 200) begin
            step();
            j++;
        end
        auto_pct[0] = 0;
        auto_pct[1] = 0;
        chk("t4_six_grants", ready_log.size() >= 6, 1'b1);
        for (int i = 0; i < 6; i++) chk("t4_grant_order", ready_log[i], i % 2);
        drain();

        // timeout then prompt recovery on m1
        delays[ridx % 1024] = 100;
        set_req(1, 1'b0, 32'h44, 32'h0, 32'h0);
        wait_ready(1, 20, k);
        chk("t5_busy_len", last_len, 4);
        chk("t5_err", m1_err, 1'b1);
        chk("t5_rd_data", m1_rd_data, 32'h0);
        delays[ridx % 1024] = 1;
        rdv[ridx % 1024]    = 32'h12345678;
        set_req(1, 1'b0, 32'h48, 32'h0, 32'h0);
        wait_ready(1, 20, k);
        chk("t5_recover_err", m1_err, 1'b0);
        chk("t5_recover_rd", m1_rd_data, 32'h12345678);

        // late ready on cycle 3, then ready exactly on the timeout cycle
        delays[ridx % 1024] = 3;
        rdv[ridx % 1024]    = 32'hBEEF0003;
        set_req(0, 1'b0, 32'h40, 32'h0, 32'h0);
        wait_ready(0, 20, k);
        chk("t6_busy_len", last_len, 3);
        chk("t6_addr_stable", last_stable, 1'b1);
        chk("t6_err", m0_err, 1'b0);
        chk("t6_rd_data", m0_rd_data, 32'hBEEF0003);
        delays[ridx % 1024] = TO;
        rdv[ridx % 1024]    = 32'hBEEF0004;
        set_req(1, 1'b0, 32'h50, 32'h0, 32'h0);
        wait_ready(1, 20, k);
        chk("t6_edge_len", last_len, TO);
        chk("t6_edge_err", m1_err, 1'b0);
        chk("t6_edge_rd", m1_rd_data, 32'hBEEF0004);

        // reset in the middle of a stalled access
        delays[ridx % 1024] = 100;
        set_req(1, 1'b0, 32'h80, 32'h0, 32'h0);
        step();
        step();
        chk("t7_busy_before_reset", bus_req, 1'b1);
        n0 = ready_log.size();
        pulse_reset();
        chk("t7_addr_cleared", bus_addr, 32'h0);
        repeat (6) step();
        chk("t7_no_ready_pulse", ready_log.size(), n0);

        // random traffic with one asynchronous reset in the middle
        auto_pct[0] = 35;
        auto_pct[1] = 35;
        for (int i = 0; i < 1500; i++) begin
            step();
            if (i == 700) begin
                auto_pct[0] = 0;
                auto_pct[1] = 0;
                pulse_reset();
                auto_pct[0] = 35;
                auto_pct[1] = 35;
            end
        end
        auto_pct[0] = 0;
        auto_pct[1] = 0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
